uart_tx: RTL and testbench

//  UART transmitter that sends one 8N1 frame: 1 start bit, 8 data bits LSB

---
 rtl/uart_tx.sv | 126 ++++++++++++
 tb/tb_uart_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit.
// tx and busy are registered and drive the pad/host directly.
module uart_tx #(
  parameter int unsigned TICKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CNT_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             bit_done;

  assign bit_done = (tick_cnt_q == TICK_LAST);

  // Next-state and next-output logic; tx_d is the level for the coming bit slot.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        tick_cnt_d = '0;
        if (start) begin
          shift_d = data_in;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (bit_done) begin
          tick_cnt_d = '0;
          bit_idx_d  = 3'd0;
          tx_d       = shift_q[0];
          shift_d    = {1'b0, shift_q[7:1]};
          state_d    = ST_DATA;
        end else begin
          tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (bit_done) begin
          tick_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          tick_cnt_d = '0;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        tick_cnt_d = '0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // Synchronous reset aborts any frame in flight and parks the line high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized self-checking bench for uart_tx against a frame-level line model,
// with a second instance at the minimum bit period.
module tb_uart_tx;

  localparam int unsigned T  = 87;
  localparam int unsigned T2 = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic       tx;
  logic       busy;
  logic       start2;
  logic [7:0] data_in2;
  logic       tx2;
  logic       busy2;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  uart_tx #(.TICKS_PER_BIT(T)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .data_in(data_in),
    .tx     (tx),
    .busy   (busy)
  );

  uart_tx #(.TICKS_PER_BIT(T2)) dut2 (
    .clk    (clk),
    .reset  (reset),
    .start  (start2),
    .data_in(data_in2),
    .tx     (tx2),
    .busy   (busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are observed 1 time unit after the edge that produced them.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line level of frame slot k (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 20 * T) begin
      step();
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  // Sends b, compares tx every cycle against the ideal waveform and decodes at mid-bit.
  task automatic send_frame(input logic [7:0] b, input string tag,
                            input int inject_at, input int abort_at);
    logic [9:0] rx;
    int tx_errs;
    int busy_errs;
    rx        = '0;
    tx_errs   = 0;
    busy_errs = 0;
    wait_idle(tag);
    start   = 1'b1;
    data_in = b;
    step();
    start   = 1'b0;
    data_in = 8'($urandom);
    for (int c = 0; c < int'(10 * T); c++) begin
      int k;
      k = c / int'(T);
      if (tx !== exp_bit(b, k)) tx_errs++;
      if (busy !== 1'b1) busy_errs++;
      if (c % int'(T) == int'(T / 2)) rx[k] = tx;
      if (c == abort_at) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
        check({tag, "_abort_tx"}, 32'(tx), 32'd1);
        check({tag, "_abort_busy"}, 32'(busy), 32'd0);
        check({tag, "_abort_prefix_tx_errs"}, 32'(tx_errs), 32'd0);
        return;
      end
      if (c == inject_at) begin
        start   = 1'b1;
        data_in = 8'h3C;
        step();
        start   = 1'b0;
      end else begin
        step();
      end
    end
    check({tag, "_start_bit"}, 32'(rx[0]), 32'd0);
    check({tag, "_stop_bit"}, 32'(rx[9]), 32'd1);
    check({tag, "_data"}, 32'(rx[8:1]), 32'(b));
    check({tag, "_tx_errs"}, 32'(tx_errs), 32'd0);
    check({tag, "_busy_errs"}, 32'(busy_errs), 32'd0);
    check({tag, "_end_busy"}, 32'(busy), 32'd0);
    check({tag, "_end_tx"}, 32'(tx), 32'd1);
  endtask

  initial begin
    logic [7:0] worst [6];
    logic [9:0] pat;
    int errs2;
    worst = '{8'h00, 8'hFF, 8'hAA, 8'h7E, 8'h81, 8'hF0};

    reset    = 1'b0;
    start    = 1'b1;
    data_in  = 8'hFF;
    start2   = 1'b1;
    data_in2 = 8'h00;
    repeat (3) step();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx2", 32'(tx2), 32'd1);
    check("rst_busy2", 32'(busy2), 32'd0);
    start  = 1'b0;
    start2 = 1'b0;
    reset  = 1'b1;
    step();
    check("idle_tx", 32'(tx), 32'd1);

    send_frame(8'h55, "f55", -1, -1);

    foreach (worst[i]) send_frame(worst[i], $sformatf("worst%0d", i), -1, -1);

    send_frame(8'h96, "ignore_start", 300, -1);

    send_frame(8'hC3, "abort", -1, 3 * int'(T) + 10);
    send_frame(8'h5A, "post_abort", -1, -1);

    for (int i = 0; i < 10; i++) send_frame(8'($urandom), $sformatf("rand%0d", i), -1, -1);

    // Minimum bit period with start held high: 20-cycle frames, one idle cycle apart.
    errs2    = 0;
    pat      = '0;
    start2   = 1'b1;
    data_in2 = 8'hA5;
    step();
    for (int c = 0; c < 42; c++) begin
      int p;
      p = c % 21;
      if (p == 20) begin
        if (tx2 !== 1'b1 || busy2 !== 1'b0) errs2++;
      end else begin
        if (tx2 !== exp_bit(8'hA5, p / 2) || busy2 !== 1'b1) errs2++;
      end
      if (c < 20 && (c % 2) == 0) pat[c/2] = tx2;
      if (c == 41) start2 = 1'b0;
      step();
    end
    check("t2_pattern", 32'(pat), 32'(10'b1101001010));
    check("t2_waveform_errs", 32'(errs2), 32'd0);
    check("t2_held_idle_busy", 32'(busy2), 32'd0);
    check("t2_held_idle_tx", 32'(tx2), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
